// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the decode handshake.
// The fetch unit connects through master; memory and decode together sit on slave.
interface fetch_unit_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic                 ImemReq_o;
  logic [DATAWIDTH-1:0] ImemAddr_o;
  logic                 ImemGnt_i;
  logic                 ImemRspValid_i;
  logic [DATAWIDTH-1:0] ImemRspData_i;
  logic                 InstrValid_o;
  logic                 InstrReady_i;
  logic [DATAWIDTH-1:0] Instr_o;
  logic [DATAWIDTH-1:0] InstrPC_o;

  modport master (
    output ImemReq_o, ImemAddr_o, InstrValid_o, Instr_o, InstrPC_o,
    input  ImemGnt_i, ImemRspValid_i, ImemRspData_i, InstrReady_i
  );

  modport slave (
    input  ImemReq_o, ImemAddr_o, InstrValid_o, Instr_o, InstrPC_o,
    output ImemGnt_i, ImemRspValid_i, ImemRspData_i, InstrReady_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word requests, buffers up to two returned
// instructions for decode and discards in-flight responses after a redirect.
module fetch_unit #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 Redirect_i,
  input  logic [DATAWIDTH-1:0] RedirectPC_i,
  fetch_unit_if.master         bus
);

  localparam logic [DATAWIDTH-1:0] NopInstr = DATAWIDTH'(32'h0000_0013);

  typedef enum logic {StRun, StFlush} state_e;

  state_e               r_state;
  logic [DATAWIDTH-1:0] r_pc;
  logic [DATAWIDTH-1:0] r_pcq [2];
  logic [DATAWIDTH-1:0] r_bins [2];
  logic [DATAWIDTH-1:0] r_bpc [2];
  logic [1:0]           r_inflight;
  logic [1:0]           r_drop;
  logic [1:0]           r_bcnt;

  logic                 w_valid;
  logic                 w_pop;
  logic [2:0]           w_credit;
  logic                 w_req;
  logic                 w_gnt;
  logic                 w_rsp;
  logic                 w_dropping;
  logic                 w_store;
  logic                 w_pcq_wr_idx;
  logic                 w_buf_wr_idx;
  logic [1:0]           w_inflight_nx;
  logic [1:0]           w_drop_nx;
  logic [1:0]           w_bcnt_nx;
  logic [DATAWIDTH-1:0] w_redirect_pc;
  logic [DATAWIDTH-1:0] w_pcq_nx [2];
  logic [DATAWIDTH-1:0] w_bins_nx [2];
  logic [DATAWIDTH-1:0] w_bpc_nx [2];

  assign w_valid    = (r_bcnt != 2'd0);
  assign w_pop      = w_valid && bus.InstrReady_i;
  // Outstanding plus buffered may never exceed two, which is what guarantees buffer space
  assign w_credit   = 3'(r_inflight) + 3'(r_bcnt) - 3'(w_pop);
  assign w_req      = !rst_i && !Redirect_i && (w_credit < 3'd2);
  assign w_gnt      = w_req && bus.ImemGnt_i;
  assign w_rsp      = bus.ImemRspValid_i && (r_inflight != 2'd0);
  assign w_dropping = w_rsp && (r_state == StFlush);
  assign w_store    = w_rsp && !w_dropping;

  assign w_redirect_pc = RedirectPC_i & ~DATAWIDTH'(3);

  assign w_inflight_nx = r_inflight + 2'(w_gnt) - 2'(w_rsp);
  // A redirect condemns everything still outstanding once this cycle's response has resolved
  assign w_drop_nx     = Redirect_i ? (r_inflight - 2'(w_rsp)) : (r_drop - 2'(w_dropping));
  assign w_bcnt_nx     = Redirect_i ? 2'd0 : (r_bcnt - 2'(w_pop) + 2'(w_store));

  assign w_pcq_wr_idx  = (r_inflight != 2'd0) && !w_rsp;
  assign w_buf_wr_idx  = (r_bcnt != 2'd0) && !w_pop;

  always_comb begin
    w_pcq_nx = r_pcq;
    if (w_rsp) w_pcq_nx[0] = r_pcq[1];
    if (w_gnt) w_pcq_nx[w_pcq_wr_idx] = r_pc;
  end

  always_comb begin
    w_bins_nx = r_bins;
    w_bpc_nx  = r_bpc;
    if (w_pop) begin
      w_bins_nx[0] = r_bins[1];
      w_bpc_nx[0]  = r_bpc[1];
    end
    if (w_store) begin
      w_bins_nx[w_buf_wr_idx] = bus.ImemRspData_i;
      w_bpc_nx[w_buf_wr_idx]  = r_pcq[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_pcq      <= '{default: '0};
      r_bins     <= '{default: '0};
      r_bpc      <= '{default: '0};
      r_inflight <= 2'd0;
      r_drop     <= 2'd0;
      r_bcnt     <= 2'd0;
    end else begin
      unique case (r_state)
        StRun:   if (Redirect_i && (w_drop_nx != 2'd0)) r_state <= StFlush;
        StFlush: if (w_drop_nx == 2'd0) r_state <= StRun;
        default: r_state <= StRun;
      endcase
      if (Redirect_i) begin
        r_pc <= w_redirect_pc;
      end else if (w_gnt) begin
        r_pc <= r_pc + DATAWIDTH'(4);
      end
      r_pcq      <= w_pcq_nx;
      r_bins     <= w_bins_nx;
      r_bpc      <= w_bpc_nx;
      r_inflight <= w_inflight_nx;
      r_drop     <= w_drop_nx;
      r_bcnt     <= w_bcnt_nx;
    end
  end

  assign bus.ImemReq_o    = w_req;
  assign bus.ImemAddr_o   = r_pc;
  assign bus.InstrValid_o = w_valid;
  assign bus.Instr_o      = w_valid ? r_bins[0] : NopInstr;
  assign bus.InstrPC_o    = w_valid ? r_bpc[0] : '0;

endmodule
